fb_pc_ctrl: RTL and testbench

Next-PC sequencer for the `fb_pc` register, sitting between fetch and the ID/EX hazard logic.
- Each cycle it chooses the address `fb_pc` loads: sequential, JAL target, EX branch target or resolved JALR target.
- It drives the PC hold, PC clear and pipeline-flush strobes.
- A small FSM covers multi-cycle load-use stalls and the one-instruction JALR lock.
- PC addresses are word indices, so the sequential step is +1.

---
 rtl/fb_pc_ctrl_pkg.sv | 16 +
 rtl/fb_pc_ctrl_if.sv | 35 +++
 rtl/fb_pc_ctrl.sv | 107 ++++++++++
 tb/tb_fb_pc_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pc_ctrl_pkg.sv
// Shared PC-path definitions: data width, sequencer state encodings and the PC step.
// Word-indexed PCs, so the sequential step is a single increment.
package fb_defines;

    localparam int FB_32BITS = 32;
    localparam int FB_CNT_W  = 4;

    localparam logic [FB_32BITS-1:0] FB_PC_STEP = 32'd1;

    typedef enum logic [1:0] {
        FB_PCS_RUN   = 2'd0,
        FB_PCS_STALL = 2'd1,
        FB_PCS_JALR  = 2'd2
    } fb_pcs_e;

endpackage

// File: rtl/fb_pc_ctrl_if.sv
// Fetch/hazard-side bundle of the next-PC sequencer; master is the pipeline, slave the controller.
// Purely wires: no latency, and no flow control (the hold strobe is the stall mechanism).
interface fb_pc_ctrl_if;
    import fb_defines::*;

    logic [FB_32BITS-1:0] pc_address;
    logic                 id_load_hazard;
    logic                 id_jal;
    logic [FB_32BITS-1:0] id_jal_target;
    logic                 id_jalr;
    logic                 ex_branch_taken;
    logic [FB_32BITS-1:0] ex_branch_target;
    logic                 ex_jalr_valid;
    logic [FB_32BITS-1:0] ex_jalr_target;

    logic                 pc_write;
    logic [FB_32BITS-1:0] new_address;
    logic                 pc_clear;
    logic                 if_id_flush;
    logic                 id_ex_flush;
    logic [1:0]           ctrl_state;

    modport master (
        output pc_address, id_load_hazard, id_jal, id_jal_target, id_jalr,
               ex_branch_taken, ex_branch_target, ex_jalr_valid, ex_jalr_target,
        input  pc_write, new_address, pc_clear, if_id_flush, id_ex_flush, ctrl_state
    );

    modport slave (
        input  pc_address, id_load_hazard, id_jal, id_jal_target, id_jalr,
               ex_branch_taken, ex_branch_target, ex_jalr_valid, ex_jalr_target,
        output pc_write, new_address, pc_clear, if_id_flush, id_ex_flush, ctrl_state
    );

endinterface

// File: rtl/fb_pc_ctrl.sv
// Next-PC sequencer: picks sequential/JAL/branch/JALR address, drives PC hold, clear and flush strobes.
// Outputs combinational from state + inputs (redirect lands at the next edge); backpressure is pc_write=1 (hold).
module fb_pc_ctrl
    import fb_defines::*;
#(
    parameter int unsigned STALL_CYCLES = 1
) (
    input  logic          clk,
    input  logic          pc_reset,
    fb_pc_ctrl_if.slave   bus
);

    localparam logic [FB_CNT_W-1:0] CNT_INIT = FB_CNT_W'(STALL_CYCLES - 1);

    fb_pcs_e               state_q, state_d;
    logic [FB_CNT_W-1:0]   cnt_q, cnt_d;
    logic [FB_CNT_W-1:0]   cnt_dec;

    assign cnt_dec = cnt_q - FB_CNT_W'(1);

    always_ff @(posedge clk) begin
        if (pc_reset) begin
            state_q <= FB_PCS_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        bus.new_address = bus.pc_address + FB_PC_STEP;
        bus.pc_write    = 1'b0;
        bus.pc_clear    = 1'b0;
        bus.if_id_flush = 1'b0;
        bus.id_ex_flush = 1'b0;
        bus.ctrl_state  = state_q;

        case (state_q)
            FB_PCS_STALL: begin
                if (bus.ex_branch_taken) begin
                    bus.new_address = bus.ex_branch_target;
                    bus.if_id_flush = 1'b1;
                    bus.id_ex_flush = 1'b1;
                    state_d         = FB_PCS_RUN;
                    cnt_d           = '0;
                end else begin
                    bus.pc_write    = 1'b1;
                    bus.id_ex_flush = 1'b1;
                    // Leave once the count reaches zero at this edge, giving STALL_CYCLES holds in total.
                    cnt_d           = (cnt_q == '0) ? '0 : cnt_dec;
                    if (cnt_q <= FB_CNT_W'(1))
                        state_d = FB_PCS_RUN;
                end
            end

            FB_PCS_JALR: begin
                if (bus.ex_jalr_valid) begin
                    bus.new_address = bus.ex_jalr_target;
                    bus.if_id_flush = 1'b1;
                    state_d         = FB_PCS_RUN;
                end else begin
                    bus.pc_write = 1'b1;
                    bus.pc_clear = 1'b1;
                end
            end

            default: begin
                // RUN and the unused encoding share this path; the latter falls back to RUN.
                state_d = FB_PCS_RUN;
                if (bus.ex_branch_taken) begin
                    bus.new_address = bus.ex_branch_target;
                    bus.if_id_flush = 1'b1;
                    bus.id_ex_flush = 1'b1;
                end else if (bus.id_load_hazard) begin
                    bus.pc_write    = 1'b1;
                    bus.id_ex_flush = 1'b1;
                    if (STALL_CYCLES > 1) begin
                        state_d = FB_PCS_STALL;
                        cnt_d   = CNT_INIT;
                    end
                end else if (bus.id_jal) begin
                    bus.new_address = bus.id_jal_target;
                    bus.if_id_flush = 1'b1;
                end else if (bus.id_jalr) begin
                    bus.pc_write = 1'b1;
                    bus.pc_clear = 1'b1;
                    state_d      = FB_PCS_JALR;
                end
            end
        endcase

        if (pc_reset) begin
            state_d         = FB_PCS_RUN;
            cnt_d           = '0;
            bus.new_address = '0;
            bus.pc_write    = 1'b1;
            bus.pc_clear    = 1'b0;
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
            bus.ctrl_state  = FB_PCS_RUN;
        end
    end

endmodule

// File: tb/tb_fb_pc_ctrl.sv
// Bench for fb_pc_ctrl: fb_pc is emulated in the bench and fed back; outputs checked against a cycle-stamp model.
module tb_fb_pc_ctrl;
    import fb_defines::*;

    localparam int STALL_N = 3;

    typedef struct packed {
        logic        pc_write;
        logic [31:0] new_address;
        logic        pc_clear;
        logic        if_id_flush;
        logic        id_ex_flush;
        logic [1:0]  ctrl_state;
    } out_t;

    logic        clk = 1'b0;
    logic        pc_reset;
    logic [31:0] pc_reg;
    int          n_chk, n_fail;

    // Model: absolute cycle number, the cycle at which a load-use stall ends, and a pending JALR.
    int          cyc;
    int          stall_end;
    bit          jalr_pend;

    always #5 clk = ~clk;

    fb_pc_ctrl_if bus ();

    fb_pc_ctrl #(.STALL_CYCLES(STALL_N)) dut (
        .clk      (clk),
        .pc_reset (pc_reset),
        .bus      (bus)
    );

    function automatic out_t model();
        out_t e;
        bit   in_stall;
        in_stall      = (cyc < stall_end);
        e.pc_write    = 1'b0;
        e.new_address = bus.pc_address + 32'd1;
        e.pc_clear    = 1'b0;
        e.if_id_flush = 1'b0;
        e.id_ex_flush = 1'b0;
        e.ctrl_state  = in_stall ? 2'd1 : 2'd0;
        if (pc_reset) begin
            e.pc_write = 1'b1; e.new_address = 32'd0; e.if_id_flush = 1'b1;
            e.id_ex_flush = 1'b1; e.ctrl_state = 2'd0;
        end else if (jalr_pend) begin
            e.ctrl_state = 2'd2;
            if (bus.ex_jalr_valid) begin
                e.new_address = bus.ex_jalr_target; e.if_id_flush = 1'b1;
            end else begin
                e.pc_write = 1'b1; e.pc_clear = 1'b1;
            end
        end else if (bus.ex_branch_taken) begin
            e.new_address = bus.ex_branch_target; e.if_id_flush = 1'b1; e.id_ex_flush = 1'b1;
        end else if (in_stall || bus.id_load_hazard) begin
            e.pc_write = 1'b1; e.id_ex_flush = 1'b1;
        end else if (bus.id_jal) begin
            e.new_address = bus.id_jal_target; e.if_id_flush = 1'b1;
        end else if (bus.id_jalr) begin
            e.pc_write = 1'b1; e.pc_clear = 1'b1;
        end
        return e;
    endfunction

    task automatic model_advance();
        bit in_stall;
        in_stall = (cyc < stall_end);
        if (pc_reset) begin
            stall_end = 0; jalr_pend = 1'b0;
        end else if (jalr_pend) begin
            if (bus.ex_jalr_valid) jalr_pend = 1'b0;
        end else if (bus.ex_branch_taken) begin
            stall_end = 0;
        end else if (in_stall) begin
            stall_end = stall_end;
        end else if (bus.id_load_hazard) begin
            stall_end = cyc + STALL_N;
        end else if (!bus.id_jal && bus.id_jalr) begin
            jalr_pend = 1'b1;
        end
        cyc++;
    endtask

    // One clock: present pc, settle, sample expected/observed, then clock the emulated fb_pc.
    task automatic step(output out_t exp, output out_t obs);
        bus.pc_address = pc_reg;
        #1;
        exp = model();
        obs.pc_write    = bus.pc_write;
        obs.new_address = bus.new_address;
        obs.pc_clear    = bus.pc_clear;
        obs.if_id_flush = bus.if_id_flush;
        obs.id_ex_flush = bus.id_ex_flush;
        obs.ctrl_state  = bus.ctrl_state;
        model_advance();
        @(posedge clk);
        if (pc_reset)           pc_reg = 32'd0;
        else if (!obs.pc_write) pc_reg = obs.new_address;
        #1;
    endtask

    task automatic idle_inputs();
        pc_reset             = 1'b0;
        bus.id_load_hazard   = 1'b0;
        bus.id_jal           = 1'b0;
        bus.id_jal_target    = 32'd0;
        bus.id_jalr          = 1'b0;
        bus.ex_branch_taken  = 1'b0;
        bus.ex_branch_target = 32'd0;
        bus.ex_jalr_valid    = 1'b0;
        bus.ex_jalr_target   = 32'd0;
    endtask

    task automatic test_reset();
        out_t e, o;
        out_t rst_val;
        idle_inputs();
        pc_reset = 1'b1;
        rst_val = '{pc_write: 1'b1, new_address: 32'd0, pc_clear: 1'b0,
                    if_id_flush: 1'b1, id_ex_flush: 1'b1, ctrl_state: 2'd0};
        step(e, o);
        n_chk++;
        if (o !== rst_val) begin n_fail++; $display("FAIL reset_outputs: got %h expected %h", o, rst_val); end
        n_chk++;
        if (pc_reg !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", pc_reg); end
        pc_reset = 1'b0;
    endtask

    task automatic test_free_run();
        out_t e, o;
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (pc_reg !== 32'(i)) begin n_fail++; $display("FAIL run_pc: got %h expected %h", pc_reg, i); end
            step(e, o);
            n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL run_outputs: got %h expected %h", o, e); end
        end
        pc_reg = 32'hFFFF_FFFF;
        step(e, o);
        n_chk++;
        if (o.new_address !== 32'd0) begin n_fail++; $display("FAIL wrap_addr: got %h expected 0", o.new_address); end
        n_chk++;
        if (pc_reg !== 32'd0) begin n_fail++; $display("FAIL wrap_pc: got %h expected 0", pc_reg); end
    endtask

    task automatic test_branch();
        out_t e, o;
        idle_inputs();
        pc_reg = 32'd5;
        bus.ex_branch_taken = 1'b1; bus.ex_branch_target = 32'h40;
        bus.id_jal = 1'b1; bus.id_jal_target = 32'h77;
        step(e, o);
        n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL branch_outputs: got %h expected %h", o, e); end
        idle_inputs();
        n_chk++;
        if (pc_reg !== 32'h40) begin n_fail++; $display("FAIL branch_pc: got %h expected 40", pc_reg); end
        step(e, o);
        n_chk++;
        if ({o.if_id_flush, o.id_ex_flush} !== 2'b00) begin
            n_fail++; $display("FAIL branch_one_cycle: got %b expected 00", {o.if_id_flush, o.id_ex_flush});
        end
    endtask

    task automatic test_load_stall();
        out_t e, o;
        int   exp_pc[4] = '{8, 8, 8, 9};
        idle_inputs();
        pc_reg = 32'd8;
        for (int k = 0; k < 4; k++) begin
            bus.id_load_hazard = (k == 0);
            bus.id_jal = (k == 1 || k == 2); bus.id_jal_target = 32'h333;
            step(e, o);
            n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL stall_outputs[%0d]: got %h expected %h", k, o, e); end
            n_chk++;
            if (pc_reg !== 32'(exp_pc[k])) begin
                n_fail++; $display("FAIL stall_pc[%0d]: got %h expected %h", k, pc_reg, exp_pc[k]);
            end
            if (k == 1) begin
                n_chk++;
                if (o.ctrl_state !== 2'd1) begin n_fail++; $display("FAIL stall_state: got %0d expected 1", o.ctrl_state); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_jalr();
        out_t e, o;
        int   holds;
        idle_inputs();
        pc_reg = 32'd10;
        bus.id_jalr = 1'b1;
        step(e, o);
        n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL jalr_issue: got %h expected %h", o, e); end
        bus.id_jalr = 1'b0; bus.ex_jalr_valid = 1'b1; bus.ex_jalr_target = 32'h100;
        step(e, o);
        n_chk++;
        if (o.if_id_flush !== 1'b1 || o !== e) begin n_fail++; $display("FAIL jalr_resolve: got %h expected %h", o, e); end
        n_chk++;
        if (pc_reg !== 32'h100) begin n_fail++; $display("FAIL jalr_pc: got %h expected 100", pc_reg); end
        idle_inputs();
        holds = 0;
        bus.id_jalr = 1'b1;
        step(e, o);
        holds += int'(o.pc_write);
        bus.id_jalr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.ex_jalr_valid = (k == 3); bus.ex_jalr_target = 32'h200;
            bus.id_load_hazard = (k == 1);
            step(e, o);
            holds += int'(o.pc_write);
            n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL jalr_wait[%0d]: got %h expected %h", k, o, e); end
        end
        n_chk++;
        if (holds != 4) begin n_fail++; $display("FAIL jalr_hold_len: got %0d expected 4", holds); end
        n_chk++;
        if (pc_reg !== 32'h200) begin n_fail++; $display("FAIL jalr_late_pc: got %h expected 200", pc_reg); end
        idle_inputs();
    endtask

    task automatic test_branch_vs_jalr();
        out_t e, o;
        idle_inputs();
        pc_reg = 32'd20;
        bus.ex_branch_taken = 1'b1; bus.ex_branch_target = 32'h80; bus.id_jalr = 1'b1;
        step(e, o);
        n_chk++;
        if (o.pc_clear !== 1'b0 || o.new_address !== 32'h80) begin
            n_fail++; $display("FAIL br_jalr_clear: got %h expected %h", o, e);
        end
        idle_inputs();
        step(e, o);
        n_chk++;
        if (o.ctrl_state !== 2'd0 || o.pc_write !== 1'b0 || pc_reg !== 32'h81) begin
            n_fail++; $display("FAIL br_jalr_no_wait: got state %0d write %b pc %h expected 0 0 81",
                               o.ctrl_state, o.pc_write, pc_reg);
        end
    endtask

    task automatic test_reset_mid();
        out_t e, o;
        for (int m = 0; m < 2; m++) begin
            idle_inputs();
            pc_reg = 32'd30;
            if (m == 0) bus.id_load_hazard = 1'b1; else bus.id_jalr = 1'b1;
            step(e, o);
            idle_inputs();
            step(e, o);
            pc_reset = 1'b1;
            step(e, o);
            n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL reset_mid_outputs[%0d]: got %h expected %h", m, o, e); end
            pc_reset = 1'b0;
            bus.ex_jalr_valid = 1'b1; bus.ex_jalr_target = 32'h999;
            step(e, o);
            n_chk++;
            if (o.ctrl_state !== 2'd0 || pc_reg !== 32'd1) begin
                n_fail++; $display("FAIL reset_mid_restart[%0d]: got state %0d pc %h expected 0 1", m, o.ctrl_state, pc_reg);
            end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        out_t e, o;
        int   bad;
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            pc_reset             = ($urandom_range(63) == 0);
            bus.id_load_hazard   = ($urandom_range(7) == 0);
            bus.id_jal           = ($urandom_range(7) == 0);
            bus.id_jal_target    = $urandom;
            bus.id_jalr          = ($urandom_range(9) == 0);
            bus.ex_branch_taken  = ($urandom_range(7) == 0);
            bus.ex_branch_target = $urandom;
            bus.ex_jalr_valid    = ($urandom_range(2) == 0);
            bus.ex_jalr_target   = $urandom;
            step(e, o);
            n_chk++;
            if (o !== e) begin
                n_fail++; bad++;
                if (bad <= 10) $display("FAIL random[%0d]: got %h expected %h", i, o, e);
            end
        end
        idle_inputs();
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        cyc = 0; stall_end = 0; jalr_pend = 1'b0;
        pc_reg = 32'd0;
        idle_inputs();
        bus.pc_address = 32'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_free_run();
        test_branch();
        test_load_stall();
        test_jalr();
        test_branch_vs_jalr();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
